// File: rtl/smc_cfg_pkg.sv
// smc_cfg_pkg
// Shared definitions for the SMC config-register reader and any checker that
// needs to interpret the config word: FSM state encoding, field positions
// within the 32-bit config word, the default signature, and the decoded
// field bundle.
package smc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_AUTO = 3'd0,
        ST_IDLE = 3'd1,
        ST_SEL  = 3'd2,
        ST_CHK  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int NUM_CS_LSB = 0;
    localparam int NUM_CS_W   = 8;
    localparam int MODE_LSB   = 8;
    localparam int MODE_W     = 14;
    localparam int SIG_LSB    = 30;
    localparam int SIG_W      = 2;

    localparam logic [SIG_W-1:0] SIG_DEFAULT = 2'b11;

    // Decoded view of one config word; the raw word travels with its fields
    // so the accepted word and its slices are always loaded together.
    typedef struct packed {
        logic [31:0]         word;
        logic [SIG_W-1:0]    sig;
        logic [MODE_W-1:0]   mode;
        logic [NUM_CS_W-1:0] num_cs;
    } cfg_fields_t;

endpackage

// File: rtl/smc_cfg_reader_decode.sv
// smc_cfg_decode
// Purely combinational slicing of a 32-bit SMC config word into its fields.
// Also used by the register slice's checker, so it carries no state.
// Ports:
//   word_i   [31:0]  raw config word
//   fields_o         decoded fields plus the raw word (cfg_fields_t)
module smc_cfg_decode
    import smc_cfg_pkg::*;
(
    input  logic [31:0] word_i,
    output cfg_fields_t fields_o
);

    assign fields_o = '{
        word:   word_i,
        sig:    word_i[SIG_LSB +: SIG_W],
        mode:   word_i[MODE_LSB +: MODE_W],
        num_cs: word_i[NUM_CS_LSB +: NUM_CS_W]
    };

endmodule

// File: rtl/smc_cfg_reader.sv
// smc_cfg_reader
// Initiator for the SMC read-only config register. Selects the register,
// samples rdata on NUM_SAMPLES consecutive cycles, requires all samples to
// match and the signature bits to equal SIG, retries up to MAX_RETRY times,
// then publishes the registered, decoded fields with a start/busy/done
// handshake. Runs once automatically after reset and again on each start.
//
// Optional feature macro: SMC_CFG_REFRESH_EN
//   When defined, a 16-bit idle down-counter re-triggers a read every 65536
//   idle cycles. A refresh keeps cfg_valid and the fields until CHK; a failed
//   refresh leaves them untouched and raises cfg_err alongside cfg_valid.
//
// Ports:
//   hclk         in   system clock
//   n_sys_reset  in   asynchronous active-low reset
//   start        in   one-cycle read request, honoured only in IDLE
//   selreg       out  select to the config register
//   rdata        in   [31:0] config register data (combinational on selreg)
//   busy         out  read sequence in progress
//   done         out  one-cycle pulse, cfg_valid/cfg_err updated
//   cfg_valid    out  decoded fields valid
//   cfg_err      out  retries exhausted
//   num_cs       out  [7:0]  accepted word [7:0]
//   mode_fields  out  [13:0] accepted word [21:8], field0 in [1:0]
//   sig_flags    out  [1:0]  accepted word [31:30]
//   cfg_word     out  [31:0] accepted word
//
// state | meaning
// AUTO  | first cycle after reset; launches a read without start
// IDLE  | waiting for start (or refresh tick)
// SEL   | selreg high, one rdata sample per cycle
// CHK   | judge stability + signature; accept, retry or give up
// GAP   | one deselected cycle between retries
// DONE  | done pulse, retry count cleared
module smc_cfg_reader
    import smc_cfg_pkg::*;
#(
    parameter int               NUM_SAMPLES = 2,
    parameter int               MAX_RETRY   = 3,
    parameter logic [SIG_W-1:0] SIG         = SIG_DEFAULT
) (
    input  logic        hclk,
    input  logic        n_sys_reset,
    input  logic        start,
    output logic        selreg,
    input  logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        cfg_valid,
    output logic        cfg_err,
    output logic [7:0]  num_cs,
    output logic [13:0] mode_fields,
    output logic [1:0]  sig_flags,
    output logic [31:0] cfg_word
);

    localparam logic [3:0] LAST_SAMPLE = 4'(NUM_SAMPLES - 1);
    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

    state_e      state_q;
    logic        selreg_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic        err_q;
    cfg_fields_t cfg_q;
    logic [31:0] first_word_q;
    logic        mismatch_q;
    logic [3:0]  sample_cnt_q;
    logic [3:0]  retry_cnt_q;

    cfg_fields_t fields_chk;
    logic        refresh_tick;

    smc_cfg_decode u_decode (
        .word_i   (first_word_q),
        .fields_o (fields_chk)
    );

`ifdef SMC_CFG_REFRESH_EN
    // Reloaded whenever the FSM is busy, so the 65536 cycles are counted
    // from entry into IDLE.
    logic [15:0] refresh_cnt_q;

    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            refresh_cnt_q <= 16'hFFFF;
        end else if (state_q != ST_IDLE) begin
            refresh_cnt_q <= 16'hFFFF;
        end else if (refresh_cnt_q != 16'd0) begin
            refresh_cnt_q <= refresh_cnt_q - 16'd1;
        end
    end

    assign refresh_tick = (state_q == ST_IDLE) && (refresh_cnt_q == 16'd0);
`else
    assign refresh_tick = 1'b0;
`endif

    always_ff @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q      <= ST_AUTO;
            selreg_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            cfg_q        <= '0;
            first_word_q <= '0;
            mismatch_q   <= 1'b0;
            sample_cnt_q <= '0;
            retry_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_AUTO: begin
                    state_q      <= ST_SEL;
                    selreg_q     <= 1'b1;
                    busy_q       <= 1'b1;
                    sample_cnt_q <= '0;
                    mismatch_q   <= 1'b0;
                end
                ST_IDLE: begin
                    if (start || refresh_tick) begin
                        // An explicit request invalidates the old config; a
                        // refresh keeps publishing it until the new verdict.
                        if (start) begin
                            valid_q <= 1'b0;
                            err_q   <= 1'b0;
                        end
                        state_q      <= ST_SEL;
                        selreg_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        sample_cnt_q <= '0;
                        mismatch_q   <= 1'b0;
                    end
                end
                ST_SEL: begin
                    if (sample_cnt_q == 4'd0) begin
                        first_word_q <= rdata;
                    end else if (rdata != first_word_q) begin
                        mismatch_q <= 1'b1;
                    end
                    if (sample_cnt_q >= LAST_SAMPLE) begin
                        state_q  <= ST_CHK;
                        selreg_q <= 1'b0;
                    end else begin
                        sample_cnt_q <= sample_cnt_q + 4'd1;
                    end
                end
                ST_CHK: begin
                    if (!mismatch_q && (fields_chk.sig == SIG)) begin
                        cfg_q   <= fields_chk;
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (retry_cnt_q < MAX_RETRY_C) begin
                        retry_cnt_q <= retry_cnt_q + 4'd1;
                        state_q     <= ST_GAP;
                    end else begin
                        // Fields and cfg_valid are left as they are: cleared
                        // by start, or still the previous word on a refresh.
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state_q      <= ST_SEL;
                    selreg_q     <= 1'b1;
                    sample_cnt_q <= '0;
                    mismatch_q   <= 1'b0;
                end
                ST_DONE: begin
                    retry_cnt_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    selreg_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign selreg      = selreg_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_valid   = valid_q;
    assign cfg_err     = err_q;
    assign num_cs      = cfg_q.num_cs;
    assign mode_fields = cfg_q.mode;
    assign sig_flags   = cfg_q.sig;
    assign cfg_word    = cfg_q.word;

endmodule

// File: tb/tb_smc_cfg_reader.sv
module tb_smc_cfg_reader;

    localparam int NS   = 2;
    localparam int MR   = 3;
    localparam int NATT = MR + 1;

    logic        hclk = 1'b0;
    logic        n_sys_reset = 1'b0;
    logic        start = 1'b0;
    logic        selreg;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        cfg_valid;
    logic        cfg_err;
    logic [7:0]  num_cs;
    logic [13:0] mode_fields;
    logic [1:0]  sig_flags;
    logic [31:0] cfg_word;

    always #5 hclk = ~hclk;

    smc_cfg_reader dut (
        .hclk        (hclk),
        .n_sys_reset (n_sys_reset),
        .start       (start),
        .selreg      (selreg),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .cfg_valid   (cfg_valid),
        .cfg_err     (cfg_err),
        .num_cs      (num_cs),
        .mode_fields (mode_fields),
        .sig_flags   (sig_flags),
        .cfg_word    (cfg_word)
    );

    // Config register responder: word presented depends on which attempt
    // and which sample within the burst the reader is on.
    logic [31:0] tbl [NATT][NS];
    logic [1:0]  att_idx;
    logic [0:0]  smp_idx;
    logic        sel_prev;
    int          bursts_total = 0;
    int          sel_cycles_total = 0;

    assign rdata = selreg ? tbl[att_idx][smp_idx] : 32'h0;

    always @(posedge hclk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            att_idx  <= '0;
            smp_idx  <= '0;
            sel_prev <= 1'b0;
        end else begin
            sel_prev <= selreg;
            if (selreg && !sel_prev) bursts_total <= bursts_total + 1;
            if (selreg) sel_cycles_total <= sel_cycles_total + 1;
            if (!busy) begin
                att_idx <= '0;
                smp_idx <= '0;
            end else if (selreg) begin
                if (smp_idx == 1'(NS - 1)) begin
                    smp_idx <= '0;
                    if (att_idx != 2'(NATT - 1)) att_idx <= att_idx + 2'd1;
                end else begin
                    smp_idx <= smp_idx + 1'b1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the reader should be publishing.
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_word;
    bit          p_pass;
    int          p_att;

    // An attempt succeeds when every sample equals the first and the top two
    // bits are 2'b11; the first successful attempt within MR+1 tries wins.
    function automatic void predict(output bit pass, output int attempts, output logic [31:0] word);
        bit stable;
        pass = 1'b0;
        attempts = 0;
        word = '0;
        for (int a = 0; a < NATT; a++) begin
            stable = 1'b1;
            attempts = a + 1;
            for (int s = 1; s < NS; s++)
                if (tbl[2'(a)][1'(s)] !== tbl[2'(a)][0]) stable = 1'b0;
            if (stable && (tbl[2'(a)][0] >> 30) == 32'd3) begin
                pass = 1'b1;
                word = tbl[2'(a)][0];
                return;
            end
        end
    endfunction

    // Applies one sequence's outcome to the model; from_start mirrors the
    // clear that a start (or reset) performs.
    task automatic model_sequence(input bit from_start);
        logic [31:0] w;
        if (from_start) begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
        predict(p_pass, p_att, w);
        if (p_pass) begin
            m_valid = 1'b1;
            m_err   = 1'b0;
            m_word  = w;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic fill_tbl(input logic [31:0] w);
        for (int a = 0; a < NATT; a++)
            for (int s = 0; s < NS; s++)
                tbl[2'(a)][1'(s)] = w;
    endtask

    // Call at a negedge with start or reset release already applied.
    // Returns the cycle count from first selreg-high cycle to the done cycle.
    task automatic run_measure(output int lat, output int bursts, output int selcyc);
        int  b0, s0, c;
        bit  seen;
        b0 = bursts_total;
        s0 = sel_cycles_total;
        lat = -1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge hclk);
            start = 1'b0;
            if (selreg === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL sel_rise: selreg not seen, want high within 20 cycles");
        end else begin
            c = 1;
            for (int i = 0; i < 200 && done !== 1'b1; i++) begin
                @(negedge hclk);
                c++;
            end
            if (done === 1'b1) lat = c;
            else begin
                n_checks++;
                $display("FAIL done_wait: no done pulse within 200 cycles");
            end
        end
        bursts = bursts_total - b0;
        selcyc = sel_cycles_total - s0;
    endtask

    task automatic check_outcome(input string tag, input int lat, input int bursts, input int selcyc);
        n_checks++;
        if (lat !== p_att * (NS + 2)) $display("FAIL %s_latency: got %0d want %0d", tag, lat, p_att * (NS + 2));
        else n_pass++;
        n_checks++;
        if (bursts !== p_att) $display("FAIL %s_bursts: got %0d want %0d", tag, bursts, p_att);
        else n_pass++;
        n_checks++;
        if (selcyc !== p_att * NS) $display("FAIL %s_sel_cycles: got %0d want %0d", tag, selcyc, p_att * NS);
        else n_pass++;
        n_checks++;
        if ({cfg_valid, cfg_err} !== {m_valid, m_err})
            $display("FAIL %s_flags: got valid=%0b err=%0b want valid=%0b err=%0b", tag, cfg_valid, cfg_err, m_valid, m_err);
        else n_pass++;
        n_checks++;
        if (cfg_word !== m_word) $display("FAIL %s_word: got %h want %h", tag, cfg_word, m_word);
        else n_pass++;
        n_checks++;
        if ({sig_flags, mode_fields, num_cs} !== {m_word[31:30], m_word[21:8], m_word[7:0]})
            $display("FAIL %s_fields: got sig=%b mode=%h cs=%h want word %h", tag, sig_flags, mode_fields, num_cs, m_word);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_busy_at_done: got %0b want 0", tag, busy);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_word  = '0;
    endtask

    task automatic test_reset();
        int lat, b, sc;
        fill_tbl(32'hC000_0001);
        n_sys_reset = 1'b0;
        repeat (3) @(negedge hclk);
        n_checks++;
        if ({selreg, busy, done, cfg_valid, cfg_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {selreg, busy, done, cfg_valid, cfg_err});
        else n_pass++;
        n_checks++;
        if ({cfg_word, num_cs, mode_fields, sig_flags} !== 56'h0)
            $display("FAIL reset_fields: got word=%h cs=%h want 0", cfg_word, num_cs);
        else n_pass++;
        model_reset();
        model_sequence(1'b1);
        n_sys_reset = 1'b1;
        run_measure(lat, b, sc);
        check_outcome("auto", lat, b, sc);
        n_checks++;
        if (num_cs !== 8'h01) $display("FAIL auto_num_cs: got %h want 01", num_cs);
        else n_pass++;
    endtask

    task automatic test_bad_sig();
        int lat, b, sc;
        fill_tbl(32'h4000_0001);
        n_sys_reset = 1'b0;
        repeat (2) @(negedge hclk);
        model_reset();
        model_sequence(1'b1);
        n_sys_reset = 1'b1;
        run_measure(lat, b, sc);
        check_outcome("badsig", lat, b, sc);
        n_checks++;
        if ({cfg_err, cfg_valid, num_cs} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL badsig_err: got err=%0b valid=%0b cs=%h want 1 0 00", cfg_err, cfg_valid, num_cs);
        else n_pass++;
    endtask

    task automatic test_retry_once();
        int lat, b, sc;
        @(negedge hclk);
        fill_tbl(32'hC000_0001);
        tbl[0][1] = 32'hC000_0005;
        model_sequence(1'b1);
        start = 1'b1;
        run_measure(lat, b, sc);
        check_outcome("retry1", lat, b, sc);
        n_checks++;
        if (cfg_word !== 32'hC000_0001 || b !== 2)
            $display("FAIL retry1_result: got word=%h bursts=%0d want C0000001 2", cfg_word, b);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int  b0;
        bit  got_done, valid_low;
        @(negedge hclk);
        fill_tbl(32'hC000_0007);
        b0 = bursts_total;
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        @(negedge hclk);
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 50 && !got_done; i++) begin
            if (done === 1'b1) got_done = 1'b1;
            else @(negedge hclk);
        end
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        repeat (3) @(negedge hclk);
        n_checks++;
        if (!got_done || busy !== 1'b0 || selreg !== 1'b0 || (bursts_total - b0) !== 1)
            $display("FAIL start_ignored: got done_seen=%0b busy=%0b bursts=%0d want 1 0 1",
                     got_done, busy, bursts_total - b0);
        else n_pass++;
        n_checks++;
        if ({cfg_valid, num_cs} !== {1'b1, 8'h07}) $display("FAIL start_ignored_cfg: got valid=%0b cs=%h want 1 07", cfg_valid, num_cs);
        else n_pass++;
        m_valid = 1'b1;
        m_err = 1'b0;
        m_word = 32'hC000_0007;
        fill_tbl(32'hC000_0009);
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        n_checks++;
        if ({busy, selreg, cfg_valid} !== 3'b110)
            $display("FAIL restart_clear: got busy=%0b sel=%0b valid=%0b want 1 1 0", busy, selreg, cfg_valid);
        else n_pass++;
        valid_low = 1'b1;
        got_done = 1'b0;
        for (int i = 0; i < 50 && !got_done; i++) begin
            @(negedge hclk);
            if (done === 1'b1) got_done = 1'b1;
            else if (cfg_valid !== 1'b0) valid_low = 1'b0;
        end
        n_checks++;
        if (!got_done || !valid_low || cfg_valid !== 1'b1 || num_cs !== 8'h09)
            $display("FAIL restart_seq: got done_seen=%0b valid_low=%0b valid=%0b cs=%h want 1 1 1 09",
                     got_done, valid_low, cfg_valid, num_cs);
        else n_pass++;
        m_word = 32'hC000_0009;
    endtask

    task automatic test_reset_mid();
        int lat, b, sc;
        @(negedge hclk);
        fill_tbl(32'hC000_0002);
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        #2 n_sys_reset = 1'b0;
        #1;
        n_checks++;
        if ({selreg, busy, done, cfg_valid, cfg_err, cfg_word, num_cs, mode_fields, sig_flags} !== 61'h0)
            $display("FAIL midreset_zero: got sel=%0b busy=%0b valid=%0b word=%h want all 0",
                     selreg, busy, cfg_valid, cfg_word);
        else n_pass++;
        @(negedge hclk);
        fill_tbl(32'hC000_0003);
        model_reset();
        model_sequence(1'b1);
        n_sys_reset = 1'b1;
        run_measure(lat, b, sc);
        check_outcome("midreset", lat, b, sc);
    endtask

    task automatic test_random();
        int lat, b, sc;
        logic [31:0] w;
        logic [1:0]  sg;
        for (int it = 0; it < 10; it++) begin
            @(negedge hclk);
            for (int a = 0; a < NATT; a++) begin
                w  = $urandom;
                sg = ($urandom_range(3, 0) != 0) ? 2'b11 : 2'($urandom_range(2, 0));
                w  = {sg, w[29:0]};
                tbl[2'(a)][0] = w;
                tbl[2'(a)][1] = ($urandom_range(3, 0) == 0) ? (w ^ (32'h1 << $urandom_range(31, 0))) : w;
            end
            model_sequence(1'b1);
            start = 1'b1;
            run_measure(lat, b, sc);
            check_outcome("random", lat, b, sc);
        end
    endtask

`ifdef SMC_CFG_REFRESH_EN
    task automatic test_refresh();
        int  idle;
        bit  got_done;
        @(negedge hclk);
        fill_tbl(32'hC000_0003);
        idle = 0;
        got_done = 1'b0;
        for (int i = 0; i < 70000 && !got_done; i++) begin
            @(negedge hclk);
            if (done === 1'b1) got_done = 1'b1;
            else if (!busy) idle++;
        end
        n_checks++;
        if (!got_done || num_cs !== 8'h03 || cfg_valid !== 1'b1 || idle < 65536)
            $display("FAIL refresh: got done_seen=%0b cs=%h valid=%0b idle=%0d want 1 03 1 >=65536",
                     got_done, num_cs, cfg_valid, idle);
        else n_pass++;
    endtask
`endif

    initial begin
        fill_tbl(32'h0);
        model_reset();
        test_reset();
        test_bad_sig();
        test_retry_once();
        test_start_ignored();
        test_reset_mid();
        test_random();
`ifdef SMC_CFG_REFRESH_EN
        test_refresh();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
